// File: rtl/gbsha_fir_pkg.sv
// Shared constants and the output saturation helper for the 5-tap FIR core and its output stage.
package gbsha_fir_pkg;

    localparam int BW_in      = 6;
    localparam int BW_product = 2 * BW_in;
    localparam int BW_sum     = BW_product + 2;
    localparam int BW_out     = 8;
    localparam int MAX_SHIFT  = BW_sum - BW_out;
    localparam int SAT_W      = 8;

    localparam int signed OUT_MAX = (2 ** (BW_out - 1)) - 1;
    localparam int signed OUT_MIN = -(2 ** (BW_out - 1));

    typedef struct packed {
        logic              sat;
        logic [BW_out-1:0] val;
    } sat_res_t;

    // Clamp a BW_sum+1 bit signed value to the BW_out range and flag when clamping happened.
    function automatic sat_res_t sat_to_out(input logic signed [BW_sum:0] t);
        sat_res_t r;
        if (t > OUT_MAX) begin
            r.sat = 1'b1;
            r.val = BW_out'(OUT_MAX);
        end else if (t < OUT_MIN) begin
            r.sat = 1'b1;
            r.val = BW_out'(OUT_MIN);
        end else begin
            r.sat = 1'b0;
            r.val = t[BW_out-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/gbsha_fir_out_stage_fifo.sv
// Show-ahead synchronous FIFO; the head holds the last popped word (0 after reset) while empty.
module gbsha_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Push/pop qualification, pointer and level bookkeeping.
    always_comb begin
        do_pop_s  = pop && (level_q != '0);
        do_push_s = push && ((level_q != FULL_LVL) || do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        last_d    = last_q;
        level_d   = level_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            last_d   = mem_q[rd_ptr_q];
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            last_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            last_q   <= last_d;
        end
    end

    // Head is the oldest entry, or the last word handed out once the FIFO has drained.
    always_comb begin
        if (level_q != '0) begin
            head = mem_q[rd_ptr_q];
        end else begin
            head = last_q;
        end
        level = level_q;
    end

endmodule

// File: rtl/gbsha_fir_out_stage.sv
// FIR output stage: run-time arithmetic right shift, saturation to BW_out, FIFO with valid/ready.
// Define GBSHA_FIR_OUT_ROUND_EN for round-half-up before the shift; default truncates toward -inf.
module gbsha_fir_out_stage
    import gbsha_fir_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int SHIFT_W = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic signed [BW_sum-1:0]   in_data,
    output logic                       in_ready,
    input  logic [SHIFT_W-1:0]         shift,
    output logic                       out_valid,
    output logic signed [BW_out-1:0]   out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [SAT_W-1:0]           sat_count,
    input  logic                       clear_stats
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW:0] OCC_LIM = (LW + 1)'(DEPTH);
    localparam logic [SHIFT_W-1:0] SHIFT_LIM = SHIFT_W'(MAX_SHIFT);

    logic [SHIFT_W-1:0]       eff_s;
    logic signed [BW_sum:0]   ext_s;
    logic signed [BW_sum:0]   sum_s;
    logic signed [BW_sum:0]   t_s;
    sat_res_t                 res_s;
    logic [LW:0]              occ_s;
    logic                     in_ready_s;
    logic                     accept_s;
    logic                     sat_inc_s;
    logic                     pop_s;
    logic [LW-1:0]            level_s;
    logic [BW_out-1:0]        head_s;

    logic                     s1_valid_q, s1_valid_d;
    logic [BW_out-1:0]        s1_data_q, s1_data_d;
    logic                     s1_sat_q, s1_sat_d;
    logic [SAT_W-1:0]         sat_count_q, sat_count_d;

    // Conservative credit: stage register plus FIFO never exceed DEPTH, so stage 1 never stalls.
    always_comb begin
        occ_s      = {1'b0, level_s} + {{LW{1'b0}}, s1_valid_q};
        in_ready_s = reset && (occ_s < OCC_LIM);
        accept_s   = in_valid && in_ready_s;
    end

    // Scaler: widened by one bit so the rounding offset cannot wrap.
    always_comb begin
        if (shift > SHIFT_LIM) begin
            eff_s = SHIFT_LIM;
        end else begin
            eff_s = shift;
        end
        ext_s = {in_data[BW_sum-1], in_data};
`ifdef GBSHA_FIR_OUT_ROUND_EN
        if (eff_s != '0) begin
            sum_s = ext_s + ((BW_sum + 1)'(1) << (eff_s - SHIFT_W'(1)));
        end else begin
            sum_s = ext_s;
        end
`else
        sum_s = ext_s;
`endif
        t_s   = sum_s >>> eff_s;
        res_s = sat_to_out(t_s);
    end

    // Stage register next state: loads on accept, otherwise drains into the FIFO.
    always_comb begin
        s1_valid_d = accept_s;
        if (accept_s) begin
            s1_data_d = res_s.val;
            s1_sat_d  = res_s.sat;
        end else begin
            s1_data_d = s1_data_q;
            s1_sat_d  = s1_sat_q;
        end
    end

    // Saturation counter: sticky at the top, clear wins over a held value but not over a new event.
    always_comb begin
        sat_inc_s = s1_valid_q && s1_sat_q;
        if (clear_stats) begin
            sat_count_d = sat_inc_s ? SAT_W'(1) : SAT_W'(0);
        end else if (sat_inc_s && (sat_count_q != 8'hFF)) begin
            sat_count_d = sat_count_q + SAT_W'(1);
        end else begin
            sat_count_d = sat_count_q;
        end
    end

    // Stage-1 and statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_sat_q    <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_sat_q    <= s1_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign pop_s = (level_s != '0) && out_ready;

    gbsha_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BW_out)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (s1_valid_q),
        .push_data (s1_data_q),
        .pop       (pop_s),
        .head      (head_s),
        .level     (level_s)
    );

    // Output drive.
    always_comb begin
        in_ready   = in_ready_s;
        out_valid  = (level_s != '0);
        out_data   = head_s;
        fifo_level = level_s;
        sat_count  = sat_count_q;
    end

endmodule

// File: doc/gbsha_fir_out_stage.md
Name: gbsha_fir_out_stage

Overview:
Downstream neighbour of the 5-tap FIR core. Consumes the signed FIR accumulator (BW_sum bits) and scales it by a run-time arithmetic right shift. Saturates the result to BW_out bits and buffers it in a small FIFO with valid/ready handshake toward the pin/readout logic. Also keeps a saturating overflow counter for tuning coefficient gain.

Parameters:
BW_sum, 14, width of signed input accumulator
BW_out, 8, width of signed output sample
DEPTH, 4, FIFO entries (power of 2, >=2)
SHIFT_W, 3, width of shift select port
MAX_SHIFT, 6, largest honoured shift (= BW_sum - BW_out)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
in_valid  in  1  in_data carries a new FIR sum
in_data  in  BW_sum  signed FIR accumulator
in_ready  out  1  block can accept a sample this cycle
shift  in  SHIFT_W  right-shift amount, sampled with each accepted sample
out_valid  out  1  out_data holds FIFO head
out_data  out  BW_out  signed scaled/saturated sample
out_ready  in  1  consumer takes head this cycle
fifo_level  out  clog2(DEPTH)+1  entries in FIFO (excludes stage register)
sat_count  out  8  number of saturated samples, sticks at 255
clear_stats  in  1  synchronous clear of sat_count

Behaviour:
- Reset (reset=0, async): FIFO pointers/level=0, stage register invalid, out_valid=0, out_data=0, sat_count=0, in_ready=0 while reset is held; in_ready=1 on the first cycle after release.
- Accept when in_valid & in_ready at an edge. in_ready = (fifo_level + s1_valid) < DEPTH; pop in the same cycle is ignored (conservative credit), so the stage register is never blocked.
- Stage 1 (registered): eff = min(shift, MAX_SHIFT); computed in BW_sum+1 bits: t = in_data (+ rounding, see feature) >>> eff (arithmetic); saturate t to [-2^(BW_out-1), 2^(BW_out-1)-1]; store value and sat flag.
- Stage 2: valid stage-1 entry written to FIFO on next edge. FIFO is show-ahead: out_data = head combinationally, out_valid = fifo_level != 0.
- Latency: sample accepted at edge k appears on out_valid/out_data after edge k+1 (2 cycles) when FIFO was empty.
- Pop when out_valid & out_ready. Simultaneous push+pop: level unchanged, order preserved. Pointers wrap modulo DEPTH.
- out_data holds last head (or 0 after reset) when out_valid=0; consumer must ignore it.
- sat_count: +1 on the edge a saturated sample enters the FIFO, stops at 255. clear_stats with simultaneous increment yields 1; clear alone yields 0.
- Back-to-back throughput: 1 sample/cycle while out_ready=1.

Optional Feature:
GBSHA_FIR_OUT_ROUND_EN: when defined, stage 1 adds 2^(eff-1) before shifting (eff>0), i.e. round-half-up, computed in BW_sum+1 bits to avoid wrap; saturation applies after rounding. When undefined, plain truncating arithmetic shift (round toward -inf). Saturation and all other behaviour identical in both builds.

Decomposition:
- Package gbsha_fir_pkg: BW_in/BW_product/BW_sum/BW_out constants shared with the FIR core, MAX_SHIFT, function sat_to_out (saturate BW_sum+1 -> BW_out), OUT_MAX/OUT_MIN constants.
- One sub-module: gbsha_sync_fifo (DEPTH, WIDTH; push/pop/level/head, show-ahead, async active-low reset). Scaler stays inline.

Test Plan:
- Pass-through: shift=0, in 100 then -50, out_ready=1 -> out_data 100, -50 (0x64, 0xCE) two cycles after each accept, sat_count=0.
- Saturation: shift=0, in 300 then -300 -> out 127 then -128, sat_count=2; clear_stats pulse -> 0; clear coincident with a saturating write -> 1.
- Rounding: shift=2 in 302, shift=1 in -5 -> without macro 75, -3; with GBSHA_FIR_OUT_ROUND_EN 76, -2; shift=7 in 8191 -> treated as 6 -> 127 (trunc) / 127 (round, 128 saturated, sat_count+1).
- Backpressure: out_ready=0, in_valid=1 with 6 samples (1..6) -> exactly 4 accepted, in_ready=0, fifo_level=4; raise out_ready -> outputs 1,2,3,4 in order, then 5,6 accepted and drained, no loss or duplicate.
- Streaming: 64 random samples, random shift, out_ready random 50% -> output matches reference model sequence exactly; with out_ready=1 constantly, 1 sample/cycle.
- Reset mid-operation: FIFO at level 3, drive reset=0 between edges -> out_valid=0, fifo_level=0, sat_count=0 immediately; after release first new sample emerges correctly with 2-cycle latency.
